// File: rtl/bit_serial_logic_unit.sv
// Bit-serial bitwise/reduction/logical operator engine.
// Operands are walked LSB-first, one bit per clock, between two valid/ready handshakes.
module bit_serial_logic_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_a_i,
    input  logic [WIDTH-1:0] in_b_i,
    input  logic [3:0]       in_op_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_result_o,
    output logic             out_bit_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             and_q, and_d;
    logic             or_a_q, or_a_d;
    logic             or_b_q, or_b_d;
    logic             xor_q, xor_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;
    logic             out_bit_q, out_bit_d;

    logic             a_bit;
    logic             b_bit;
    logic             word_bit;
    logic             and_n;
    logic             or_a_n;
    logic             or_b_n;
    logic             xor_n;
    logic             scalar_n;
    logic [WIDTH-1:0] word_n;

    // Operands are shifted right each SHIFT cycle, so the current bit is always bit 0.
    assign a_bit  = a_q[0];
    assign b_bit  = b_q[0];
    assign and_n  = and_q & a_bit;
    assign or_a_n = or_a_q | a_bit;
    assign or_b_n = or_b_q | b_bit;
    assign xor_n  = xor_q ^ a_bit;

    always_comb begin
        word_bit = 1'b0;
        case (op_q[2:0])
            3'd0: word_bit = a_bit & b_bit;
            3'd1: word_bit = a_bit | b_bit;
            3'd2: word_bit = ~(a_bit & b_bit);
            3'd3: word_bit = ~(a_bit | b_bit);
            3'd4: word_bit = a_bit ^ b_bit;
            3'd5: word_bit = ~(a_bit ^ b_bit);
            3'd6: word_bit = ~a_bit;
            3'd7: word_bit = a_bit;
            default: word_bit = 1'b0;
        endcase
    end

    // Final combine uses the accumulators already updated with the last bit.
    always_comb begin
        scalar_n = 1'b0;
        case (op_q[2:0])
            3'd0: scalar_n = and_n;
            3'd1: scalar_n = or_a_n;
            3'd2: scalar_n = ~and_n;
            3'd3: scalar_n = ~or_a_n;
            3'd4: scalar_n = xor_n;
            3'd5: scalar_n = ~xor_n;
            3'd6: scalar_n = or_a_n & or_b_n;
            3'd7: scalar_n = or_a_n | or_b_n;
            default: scalar_n = 1'b0;
        endcase
    end

    // New word bits enter at the MSB so bit 0 lands in place after WIDTH shifts.
    always_comb begin
        word_n            = shreg_q >> 1;
        word_n[WIDTH-1]   = word_bit;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        shreg_d      = shreg_q;
        and_d        = and_q;
        or_a_d       = or_a_q;
        or_b_d       = or_b_q;
        xor_d        = xor_q;
        in_ready_d   = in_ready_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_bit_d    = out_bit_q;

        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    a_d        = in_a_i;
                    b_d        = in_b_i;
                    op_d       = in_op_i;
                    cnt_d      = '0;
                    shreg_d    = '0;
                    and_d      = 1'b1;
                    or_a_d     = 1'b0;
                    or_b_d     = 1'b0;
                    xor_d      = 1'b0;
                    in_ready_d = 1'b0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                shreg_d = word_n;
                and_d   = and_n;
                or_a_d  = or_a_n;
                or_b_d  = or_b_n;
                xor_d   = xor_n;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    out_valid_d  = 1'b1;
                    out_result_d = op_q[3] ? '0 : word_n;
                    out_bit_d    = op_q[3] ? scalar_n : 1'b0;
                    state_d      = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            shreg_q      <= '0;
            and_q        <= 1'b1;
            or_a_q       <= 1'b0;
            or_b_q       <= 1'b0;
            xor_q        <= 1'b0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_bit_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            shreg_q      <= shreg_d;
            and_q        <= and_d;
            or_a_q       <= or_a_d;
            or_b_q       <= or_b_d;
            xor_q        <= xor_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_bit_q    <= out_bit_d;
        end
    end

    assign in_ready_o   = in_ready_q;
    assign out_valid_o  = out_valid_q;
    assign out_result_o = out_result_q;
    assign out_bit_o    = out_bit_q;

endmodule

// File: tb/tb_bit_serial_logic_unit.sv
// Randomized and directed bench for bit_serial_logic_unit (WIDTH=8),
// checked against a word-level reference model of the operator set.
module tb_bit_serial_logic_unit;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic [3:0]   in_op = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_result;
    logic         out_bit;

    int checks = 0;
    int errors = 0;
    int cycle = 0;

    bit_serial_logic_unit #(.WIDTH(W)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_a_i      (in_a),
        .in_b_i      (in_b),
        .in_op_i     (in_op),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_result_o(out_result),
        .out_bit_o   (out_bit)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Word-level reference: whole-operand operators, no bit walking.
    function automatic void model(input logic [3:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] r,
                                  output logic bo);
        r  = '0;
        bo = 1'b0;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  r = ~(a & b);
            4'd3:  r = ~(a | b);
            4'd4:  r = a ^ b;
            4'd5:  r = ~(a ^ b);
            4'd6:  r = ~a;
            4'd7:  r = a;
            4'd8:  bo = &a;
            4'd9:  bo = |a;
            4'd10: bo = ~&a;
            4'd11: bo = ~|a;
            4'd12: bo = ^a;
            4'd13: bo = ~^a;
            4'd14: bo = (|a) && (|b);
            default: bo = (|a) || (|b);
        endcase
    endfunction

    // Starts and ends just after a negedge; hold = cycles out_ready stays low in DONE.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold, output int acc_cycle);
        logic [W-1:0] exp_r;
        logic         exp_b;
        int           lat;
        model(op, a, b, exp_r, exp_b);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL in_ready_before_accept op=%0d got=%b exp=1", op, in_ready);
        end
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        acc_cycle = cycle;
        in_valid  = 1'b0;
        in_a      = W'($urandom);
        in_b      = W'($urandom);
        in_op     = 4'($urandom);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 4 * W + 10) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL in_ready_busy op=%0d got=%b exp=0", op, in_ready);
            end
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != W + 1) begin
            errors++;
            $display("[TB] FAIL latency op=%0d got=%0d exp=%0d", op, lat, W + 1);
        end
        checks++;
        if (out_result !== exp_r) begin
            errors++;
            $display("[TB] FAIL out_result op=%0d a=%h b=%h got=%h exp=%h", op, a, b, out_result, exp_r);
        end
        checks++;
        if (out_bit !== exp_b) begin
            errors++;
            $display("[TB] FAIL out_bit op=%0d a=%h b=%h got=%b exp=%b", op, a, b, out_bit, exp_b);
        end
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in_a     = W'($urandom);
            in_b     = W'($urandom);
            in_op    = 4'($urandom);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_result !== exp_r || out_bit !== exp_b || in_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL done_hold op=%0d valid=%b res=%h bit=%b rdy=%b exp 1/%h/%b/0",
                         op, out_valid, out_result, out_bit, in_ready, exp_r, exp_b);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL after_handshake op=%0d valid=%b rdy=%b exp 0/1", op, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_a     = 8'hFF;
        in_b     = 8'hFF;
        in_op    = 4'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_result !== '0 || out_bit !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs valid=%b res=%h bit=%b exp 0/00/0", out_valid, out_result, out_bit);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL post_reset valid=%b rdy=%b exp 0/1", out_valid, in_ready);
            end
        end
    endtask

    task automatic test_word_ops();
        int c;
        run_op(4'd0, 8'hF0, 8'h3C, 0, c);
        run_op(4'd1, 8'hF0, 8'h3C, 0, c);
        run_op(4'd2, 8'hF0, 8'h3C, 0, c);
        run_op(4'd3, 8'hF0, 8'h3C, 0, c);
        run_op(4'd4, 8'hF0, 8'h3C, 0, c);
        run_op(4'd7, 8'h96, 8'h00, 0, c);
    endtask

    task automatic test_back_to_back();
        int c0;
        int c1;
        run_op(4'd5, 8'hA5, 8'h0F, 0, c0);
        run_op(4'd6, 8'hA5, 8'h00, 0, c1);
        checks++;
        if (c1 - c0 != W + 2) begin
            errors++;
            $display("[TB] FAIL accept_spacing got=%0d exp=%0d", c1 - c0, W + 2);
        end
    endtask

    task automatic test_reduction();
        int c;
        run_op(4'd12, 8'h07, 8'h00, 0, c);
        run_op(4'd10, 8'hFF, 8'h00, 0, c);
        run_op(4'd11, 8'h00, 8'h00, 0, c);
        run_op(4'd8,  8'hFF, 8'h12, 0, c);
        run_op(4'd9,  8'h00, 8'hFF, 0, c);
        run_op(4'd13, 8'h07, 8'h00, 0, c);
    endtask

    task automatic test_logical();
        int c;
        run_op(4'd14, 8'h01, 8'h00, 0, c);
        run_op(4'd15, 8'h01, 8'h00, 0, c);
        run_op(4'd14, 8'h80, 8'h40, 0, c);
        run_op(4'd15, 8'h00, 8'h00, 0, c);
    endtask

    task automatic test_backpressure();
        int c;
        run_op(4'd4, 8'h5A, 8'hC3, 5, c);
        run_op(4'd12, 8'h01, 8'h00, 5, c);
    endtask

    task automatic test_reset_mid_shift();
        int c;
        bit seen;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_reset_start_ready got=%b exp=1", in_ready);
        end
        in_valid  = 1'b1;
        in_a      = 8'hFF;
        in_b      = 8'h0F;
        in_op     = 4'd1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_state rdy=%b valid=%b exp 1/0", in_ready, out_valid);
        end
        seen = 1'b0;
        repeat (2 * W) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("[TB] FAIL mid_reset_no_result got=1 exp=0");
        end
        out_ready = 1'b0;
        run_op(4'd0, 8'hF0, 8'h3C, 0, c);
    endtask

    task automatic test_random();
        int c;
        for (int i = 0; i < 50; i++) begin
            run_op(4'($urandom), W'($urandom), W'($urandom), int'($urandom_range(0, 3)), c);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        test_word_ops();
        test_back_to_back();
        test_reduction();
        test_logical();
        test_backpressure();
        test_reset_mid_shift();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
